// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU
// writebacks (req 0) and load returns (req 1). Each requester has a one-entry
// buffer and the two are granted round-robin. A per-register scoreboard tracks
// outstanding loads, and the block raises read hazards for the decode ports.
// Optional build macro: WB_BYPASS_EN forwards buffered or in-flight write data
// to the decode read ports instead of stalling them.
module regfile_wb_arbiter #(
    parameter logic [4:0] ZERO_REG = 5'd31,
    parameter logic [4:0] IO_LO    = 5'd24,
    parameter logic [4:0] IO_HI    = 5'd26
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_addr,
    input  logic [4:0]  rd_a_addr,
    input  logic [4:0]  rd_b_addr,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        fwd_a_valid,
    output logic [31:0] fwd_a_data,
    output logic        fwd_b_valid,
    output logic [31:0] fwd_b_data,
    output logic        werf,
    output logic [4:0]  rc,
    output logic [31:0] wdata,
    output logic        drop_err
);

    typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_t;

    rr_t         rr_ptr;
    logic        alu_full, mem_full;
    logic [4:0]  alu_baddr, mem_baddr;
    logic [31:0] alu_bdata, mem_bdata;
    logic [31:0] sb, sb_set, sb_clr;
    logic        grant_alu, grant_mem;
    logic        alu_acc, mem_acc, alu_drop, mem_drop;

    // Writes to the zero register or the hardware-owned I/O window are discarded.
    function automatic logic is_dropped(input logic [4:0] a);
        return (a == ZERO_REG) || ((a >= IO_LO) && (a <= IO_HI));
    endfunction

    // Round-robin grant: a lone full buffer wins, and on contention the pointer's side wins.
    always_comb begin
        grant_alu = alu_full && (!mem_full || (rr_ptr == RR_ALU));
        grant_mem = mem_full && (!alu_full || (rr_ptr == RR_MEM));
    end

    assign alu_ready = !alu_full || grant_alu;
    assign mem_ready = !mem_full || grant_mem;
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_drop  = is_dropped(alu_addr);
    assign mem_drop  = is_dropped(mem_addr);

    // Holding buffers: capture accepted non-dropped requests, empty on grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_full  <= 1'b0;
            alu_baddr <= '0;
            alu_bdata <= '0;
            mem_full  <= 1'b0;
            mem_baddr <= '0;
            mem_bdata <= '0;
        end else begin
            if (alu_acc && !alu_drop) begin
                alu_full  <= 1'b1;
                alu_baddr <= alu_addr;
                alu_bdata <= alu_data;
            end else if (grant_alu) begin
                alu_full <= 1'b0;
            end
            if (mem_acc && !mem_drop) begin
                mem_full  <= 1'b1;
                mem_baddr <= mem_addr;
                mem_bdata <= mem_data;
            end else if (grant_mem) begin
                mem_full <= 1'b0;
            end
        end
    end

    // Pointer flips only after a contended grant, so the loser wins next cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= RR_ALU;
        end else if (grant_alu && mem_full) begin
            rr_ptr <= RR_MEM;
        end else if (grant_mem && alu_full) begin
            rr_ptr <= RR_ALU;
        end
    end

    // Registered write port and drop pulse; rc/wdata hold when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            werf     <= 1'b0;
            rc       <= '0;
            wdata    <= '0;
            drop_err <= 1'b0;
        end else begin
            werf     <= grant_alu || grant_mem;
            drop_err <= (alu_acc && alu_drop) || (mem_acc && mem_drop);
            if (grant_alu) begin
                rc    <= alu_baddr;
                wdata <= alu_bdata;
            end else if (grant_mem) begin
                rc    <= mem_baddr;
                wdata <= mem_bdata;
            end
        end
    end

    // Scoreboard set/clear masks; a MEM grant or MEM drop retires the pending load.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (ld_issue && (ld_addr != ZERO_REG)) sb_set[ld_addr] = 1'b1;
        if (grant_mem) sb_clr[mem_baddr] = 1'b1;
        if (mem_acc && mem_drop) sb_clr[mem_addr] = 1'b1;
    end

    // Pending-load scoreboard; a same-edge set overrides the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~sb_clr) | sb_set;
        end
    end

    logic a_alu, a_mem, a_out, a_raw;
    logic b_alu, b_mem, b_out, b_raw;

    assign a_alu = alu_full && (alu_baddr == rd_a_addr);
    assign a_mem = mem_full && (mem_baddr == rd_a_addr);
    assign a_out = werf && (rc == rd_a_addr);
    assign a_raw = (rd_a_addr != ZERO_REG) && (sb[rd_a_addr] || a_alu || a_mem || a_out);
    assign b_alu = alu_full && (alu_baddr == rd_b_addr);
    assign b_mem = mem_full && (mem_baddr == rd_b_addr);
    assign b_out = werf && (rc == rd_b_addr);
    assign b_raw = (rd_b_addr != ZERO_REG) && (sb[rd_b_addr] || b_alu || b_mem || b_out);

`ifdef WB_BYPASS_EN
    // Read port A: forward the youngest in-flight value unless a load is still pending.
    // With both buffers matching, the side the pointer will not grant next is younger.
    always_comb begin
        fwd_a_valid = (rd_a_addr != ZERO_REG) && !sb[rd_a_addr] && (a_alu || a_mem || a_out);
        if (a_alu && a_mem) fwd_a_data = (rr_ptr == RR_ALU) ? mem_bdata : alu_bdata;
        else if (a_alu)     fwd_a_data = alu_bdata;
        else if (a_mem)     fwd_a_data = mem_bdata;
        else if (a_out)     fwd_a_data = wdata;
        else                fwd_a_data = '0;
        hazard_a = a_raw && !fwd_a_valid;
    end

    // Read port B: same forwarding rule as port A.
    always_comb begin
        fwd_b_valid = (rd_b_addr != ZERO_REG) && !sb[rd_b_addr] && (b_alu || b_mem || b_out);
        if (b_alu && b_mem) fwd_b_data = (rr_ptr == RR_ALU) ? mem_bdata : alu_bdata;
        else if (b_alu)     fwd_b_data = alu_bdata;
        else if (b_mem)     fwd_b_data = mem_bdata;
        else if (b_out)     fwd_b_data = wdata;
        else                fwd_b_data = '0;
        hazard_b = b_raw && !fwd_b_valid;
    end
`else
    // Without bypass every in-flight match stalls the reader.
    always_comb begin
        fwd_a_valid = 1'b0;
        fwd_a_data  = '0;
        fwd_b_valid = 1'b0;
        fwd_b_data  = '0;
        hazard_a    = a_raw;
        hazard_b    = b_raw;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever werf is high.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, ld_issue = 1'b0;
    logic [4:0]  alu_addr = '0, mem_addr = '0, ld_addr = '0, rd_a_addr = '0, rd_b_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, hazard_a, hazard_b, fwd_a_valid, fwd_b_valid;
    logic [31:0] fwd_a_data, fwd_b_data, wdata;
    logic        werf, drop_err;
    logic [4:0]  rc;

    regfile_wb_arbiter dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .ld_issue(ld_issue), .ld_addr(ld_addr),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .fwd_a_valid(fwd_a_valid), .fwd_a_data(fwd_a_data),
        .fwd_b_valid(fwd_b_valid), .fwd_b_data(fwd_b_data),
        .werf(werf), .rc(rc), .wdata(wdata), .drop_err(drop_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every write-port cycle must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && werf === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual rc=%0d wdata=0x%0h required no write", rc, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rc", {27'd0, rc}, {27'd0, mon_e.a});
                chk("wb_wdata", wdata, mon_e.d);
            end
        end
    end

    logic [4:0] drop_addrs [4];
    logic       drop_exp   [4];

    initial begin
        drop_addrs[0] = 5'd24; drop_exp[0] = 1'b1;
        drop_addrs[1] = 5'd26; drop_exp[1] = 1'b1;
        drop_addrs[2] = 5'd23; drop_exp[2] = 1'b0;
        drop_addrs[3] = 5'd27; drop_exp[3] = 1'b0;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_werf", {31'd0, werf}, 32'd0);
        chk("rst_rc", {27'd0, rc}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_drop_err", {31'd0, drop_err}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);

        // Reset mid-traffic: both buffers full and werf high, then async reset
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA1;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hA2;
        exp_q.push_back('{a: 5'd1, d: 32'hA1});
        tick();
        chk("cont_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("cont_mem_ready", {31'd0, mem_ready}, 32'd0);
        alu_addr = 5'd6; alu_data = 32'hA6; mem_valid = 1'b0;
        tick();
        alu_valid = 1'b0;
        chk("mid_werf", {31'd0, werf}, 32'd1);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("arst_werf", {31'd0, werf}, 32'd0);
        chk("arst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("arst_mem_ready", {31'd0, mem_ready}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            rd_a_addr = 5'(i);
            #1;
            chk("arst_hazard_a", {31'd0, hazard_a}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Single ALU write with hazard window
        rd_a_addr = 5'd5;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        exp_q.push_back('{a: 5'd5, d: 32'hDEADBEEF});
        tick();
        alu_valid = 1'b0;
        chk("single_e0_werf", {31'd0, werf}, 32'd0);
        chk("single_e0_hazard", {31'd0, hazard_a}, 32'd1);
        tick();
        chk("single_e1_werf", {31'd0, werf}, 32'd1);
        chk("single_e1_hazard", {31'd0, hazard_a}, 32'd1);
        tick();
        chk("single_e2_werf", {31'd0, werf}, 32'd0);
        chk("single_e2_hazard", {31'd0, hazard_a}, 32'd0);

        // Contention, pointer at ALU: ALU first, then MEM
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h22;
        exp_q.push_back('{a: 5'd3, d: 32'h11});
        exp_q.push_back('{a: 5'd4, d: 32'h22});
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("cont1_mem_ready", {31'd0, mem_ready}, 32'd0);
        tick(); tick(); tick();

        // Repeat: pointer moved to MEM, so MEM first
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
        exp_q.push_back('{a: 5'd4, d: 32'h44});
        exp_q.push_back('{a: 5'd3, d: 32'h33});
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("cont2_alu_ready", {31'd0, alu_ready}, 32'd0);
        tick(); tick(); tick();

        // Load scoreboard with re-issue on the clear edge
        rd_a_addr = 5'd7;
        ld_issue = 1'b1; ld_addr = 5'd7;
        tick();
        ld_issue = 1'b0;
        chk("ld_pending", {31'd0, hazard_a}, 32'd1);
        tick(); tick();
        chk("ld_pending_hold", {31'd0, hazard_a}, 32'd1);
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
        exp_q.push_back('{a: 5'd7, d: 32'h77});
        tick();
        mem_valid = 1'b0;
        ld_issue = 1'b1; ld_addr = 5'd7;
        tick();
        ld_issue = 1'b0;
        tick();
        chk("ld_reissue_hazard", {31'd0, hazard_a}, 32'd1);
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h78;
        exp_q.push_back('{a: 5'd7, d: 32'h78});
        tick();
        mem_valid = 1'b0;
        tick();
        chk("ld_final_werf_hazard", {31'd0, hazard_a}, 32'd1);
        tick();
        chk("ld_cleared", {31'd0, hazard_a}, 32'd0);

        // Zero register never hazards even when a load targets it
        ld_issue = 1'b1; ld_addr = 5'd31; rd_a_addr = 5'd31;
        tick();
        ld_issue = 1'b0;
        chk("zero_no_hazard", {31'd0, hazard_a}, 32'd0);

        // Drops: ALU to 31, MEM to pending 25
        ld_issue = 1'b1; ld_addr = 5'd25; rd_b_addr = 5'd25;
        tick();
        ld_issue = 1'b0;
        chk("drop_pending", {31'd0, hazard_b}, 32'd1);
        alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 32'hBAD0;
        mem_valid = 1'b1; mem_addr = 5'd25; mem_data = 32'hBAD1;
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("drop_err_pulse", {31'd0, drop_err}, 32'd1);
        chk("drop_clears_pending", {31'd0, hazard_b}, 32'd0);
        tick();
        chk("drop_err_clear", {31'd0, drop_err}, 32'd0);
        chk("drop_no_werf", {31'd0, werf}, 32'd0);

        // I/O window boundaries
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_addr = drop_addrs[k]; alu_data = 32'h100 + 32'(k);
            if (!drop_exp[k]) exp_q.push_back('{a: drop_addrs[k], d: 32'h100 + 32'(k)});
            tick();
            alu_valid = 1'b0;
            chk("io_drop_err", {31'd0, drop_err}, {31'd0, drop_exp[k]});
            tick(); tick();
        end

        // Bypass of a buffered ALU write
        rd_b_addr = 5'd9;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h55;
        exp_q.push_back('{a: 5'd9, d: 32'h55});
        tick();
        alu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        chk("byp_fwd_valid", {31'd0, fwd_b_valid}, 32'd1);
        chk("byp_fwd_data", fwd_b_data, 32'h55);
        chk("byp_hazard", {31'd0, hazard_b}, 32'd0);
`else
        chk("nobyp_fwd_valid", {31'd0, fwd_b_valid}, 32'd0);
        chk("nobyp_hazard", {31'd0, hazard_b}, 32'd1);
`endif
        tick(); tick(); tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
